// File: rtl/fc_data_mover_bram.sv
// FC data mover: streams N words from node/weight/bias BRAMs (port A) and accumulates node*weight+bias per 8-bit lane.
// Latency is N+2 cycles from the accepted run to o_done; there is no backpressure and the BRAMs are never written.
module fc_data_mover_bram #(
   parameter int CNT_BIT       = 31,
   parameter int DWIDTH        = 32,
   parameter int AWIDTH        = 12,
   parameter int MEM_SIZE      = 4096,
   parameter int IN_DATA_WITDH = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i_run,
   input  logic [CNT_BIT-1:0]  i_num_cnt,
   output logic                o_idle,
   output logic                o_read,
   output logic                o_write,
   output logic                o_done,
   output logic [AWIDTH-1:0]   addr_b0,
   output logic                ce_b0,
   output logic                we_b0,
   input  logic [DWIDTH-1:0]   q_b0,
   output logic [DWIDTH-1:0]   d_b0,
   output logic [AWIDTH-1:0]   addr_b1,
   output logic                ce_b1,
   output logic                we_b1,
   input  logic [DWIDTH-1:0]   q_b1,
   output logic [DWIDTH-1:0]   d_b1,
   output logic [AWIDTH-1:0]   addr_b2,
   output logic                ce_b2,
   output logic                we_b2,
   input  logic [DWIDTH-1:0]   q_b2,
   output logic [DWIDTH-1:0]   d_b2,
   output logic [31:0]         result_0,
   output logic [31:0]         result_1,
   output logic [31:0]         result_2,
   output logic [31:0]         result_3
);

   localparam int                IW           = IN_DATA_WITDH;
   localparam logic [AWIDTH-1:0] LP_ADDR_LAST = AWIDTH'(MEM_SIZE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_ce;
   logic                 r_acc_vld;
   logic [AWIDTH-1:0]    r_addr;
   logic [CNT_BIT-1:0]   r_rem;
   logic [31:0]          r_result [4];
   logic                 w_accept;

   logic [IW-1:0]        w_node [4];
   logic [IW-1:0]        w_wegt [4];
   logic [IW-1:0]        w_bias [4];
   logic [2*IW-1:0]      w_prod [4];
   logic [31:0]          w_term [4];

   assign w_accept = (r_state == S_IDLE) && i_run;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_run) begin
               w_state_nxt = (i_num_cnt == '0) ? S_DONE : S_RUN;
            end
         end
         // the last accumulation is the cycle with returned data but no read in flight
         S_RUN: begin
            if (r_acc_vld && !r_ce) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // r_rem counts the reads still to issue after the current one
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_ce      <= 1'b0;
         r_acc_vld <= 1'b0;
         r_addr    <= '0;
         r_rem     <= '0;
      end else begin
         r_acc_vld <= r_ce;
         if (w_accept) begin
            r_ce   <= (i_num_cnt != '0);
            r_addr <= '0;
            r_rem  <= i_num_cnt - 1'b1;
         end else if (r_ce) begin
            if (r_rem == '0) begin
               r_ce <= 1'b0;
            end else begin
               r_rem  <= r_rem - 1'b1;
               r_addr <= (r_addr == LP_ADDR_LAST) ? '0 : r_addr + 1'b1;
            end
         end
      end
   end

   // lane 0 is the most significant operand byte
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         w_node[k] = q_b0[DWIDTH-1-IW*k -: IW];
         w_wegt[k] = q_b1[DWIDTH-1-IW*k -: IW];
         w_bias[k] = q_b2[DWIDTH-1-IW*k -: IW];
         w_prod[k] = w_node[k] * w_wegt[k];
         w_term[k] = 32'(w_prod[k]) + 32'(w_bias[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int k = 0; k < 4; k++) begin
            r_result[k] <= '0;
         end
      end else if (w_accept) begin
         for (int k = 0; k < 4; k++) begin
            r_result[k] <= '0;
         end
      end else if (r_acc_vld) begin
         for (int k = 0; k < 4; k++) begin
            r_result[k] <= r_result[k] + w_term[k];
         end
      end
   end

   assign o_idle   = (r_state == S_IDLE);
   assign o_done   = (r_state == S_DONE);
   assign o_read   = r_ce;
   assign o_write  = r_acc_vld;

   assign addr_b0  = r_addr;
   assign addr_b1  = r_addr;
   assign addr_b2  = r_addr;
   assign ce_b0    = r_ce;
   assign ce_b1    = r_ce;
   assign ce_b2    = r_ce;
   assign we_b0    = 1'b0;
   assign we_b1    = 1'b0;
   assign we_b2    = 1'b0;
   assign d_b0     = '0;
   assign d_b1     = '0;
   assign d_b2     = '0;

   assign result_0 = r_result[0];
   assign result_1 = r_result[1];
   assign result_2 = r_result[2];
   assign result_3 = r_result[3];

endmodule

// File: tb/tb_fc_data_mover_bram.sv
// Bench for fc_data_mover_bram: BRAM models, a cycle-indexed behavioural model with a per-cycle compare, and directed runs.
module tb_fc_data_mover_bram;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          i_run;
   logic [30:0]   i_num_cnt;
   logic          o_idle, o_read, o_write, o_done;
   logic [11:0]   addr_b0, addr_b1, addr_b2;
   logic          ce_b0, ce_b1, ce_b2;
   logic          we_b0, we_b1, we_b2;
   logic [31:0]   q_b0, q_b1, q_b2;
   logic [31:0]   d_b0, d_b1, d_b2;
   logic [31:0]   result_0, result_1, result_2, result_3;

   logic [31:0]   mem0 [4096];
   logic [31:0]   mem1 [4096];
   logic [31:0]   mem2 [4096];

   int            n_cmp = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   fc_data_mover_bram dut (
      .clk(clk), .reset_n(reset_n), .i_run(i_run), .i_num_cnt(i_num_cnt),
      .o_idle(o_idle), .o_read(o_read), .o_write(o_write), .o_done(o_done),
      .addr_b0(addr_b0), .ce_b0(ce_b0), .we_b0(we_b0), .q_b0(q_b0), .d_b0(d_b0),
      .addr_b1(addr_b1), .ce_b1(ce_b1), .we_b1(we_b1), .q_b1(q_b1), .d_b1(d_b1),
      .addr_b2(addr_b2), .ce_b2(ce_b2), .we_b2(we_b2), .q_b2(q_b2), .d_b2(d_b2),
      .result_0(result_0), .result_1(result_1), .result_2(result_2), .result_3(result_3)
   );

   // single-cycle-latency read ports
   always @(posedge clk) begin
      if (ce_b0) q_b0 <= mem0[addr_b0];
      if (ce_b1) q_b1 <= mem1[addr_b1];
      if (ce_b2) q_b2 <= mem2[addr_b2];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] lane_term(input int k, input int idx);
      int          a;
      logic [31:0] n, w, b;
      a = idx % 4096;
      n = (mem0[a] >> (24 - 8 * k)) & 32'hFF;
      w = (mem1[a] >> (24 - 8 * k)) & 32'hFF;
      b = (mem2[a] >> (24 - 8 * k)) & 32'hFF;
      return n * w + b;
   endfunction

   function automatic logic [31:0] golden(input int k, input int n);
      logic [31:0] s = 0;
      for (int i = 0; i < n; i++) s += lane_term(k, i);
      return s;
   endfunction

   // Model: m_t is the cycle index since the accepted run (0 = first cycle after the run sample).
   // Reads on t<N, accumulate on 1..N, done on N+1, idle again from N+2.
   logic          m_valid = 1'b0;
   logic          m_act   = 1'b0;
   longint        m_t     = 0;
   longint        m_n     = 0;
   logic [31:0]   m_acc [4] = '{0, 0, 0, 0};

   always @(posedge clk) begin
      if (!reset_n) begin
         m_valid <= 1'b1;
         m_act   <= 1'b0;
         for (int k = 0; k < 4; k++) m_acc[k] <= 0;
      end else if (m_act) begin
         if (m_t >= 1 && m_t <= m_n)
            for (int k = 0; k < 4; k++) m_acc[k] <= m_acc[k] + lane_term(k, int'(m_t - 1));
         m_t <= m_t + 1;
         if (m_t + 1 >= m_n + 2) m_act <= 1'b0;
      end else if (i_run) begin
         m_act <= 1'b1;
         m_n   <= longint'(i_num_cnt);
         m_t   <= (i_num_cnt == 0) ? 1 : 0;
         for (int k = 0; k < 4; k++) m_acc[k] <= 0;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("o_idle",  o_idle,  !m_act);
         chk("o_read",  o_read,  m_act && m_t < m_n);
         chk("o_write", o_write, m_act && m_t >= 1 && m_t <= m_n);
         chk("o_done",  o_done,  m_act && m_t == m_n + 1);
         chk("ce_b0",   ce_b0,   m_act && m_t < m_n);
         chk("ce_b1",   ce_b1,   m_act && m_t < m_n);
         chk("ce_b2",   ce_b2,   m_act && m_t < m_n);
         chk("we_x",    {we_b0, we_b1, we_b2}, 0);
         chk("d_x",     d_b0 | d_b1 | d_b2, 0);
         if (m_act && m_t < m_n) begin
            chk("addr_b0", addr_b0, m_t % 4096);
            chk("addr_b1", addr_b1, m_t % 4096);
            chk("addr_b2", addr_b2, m_t % 4096);
         end
         chk("result_0", result_0, m_acc[0]);
         chk("result_1", result_1, m_acc[1]);
         chk("result_2", result_2, m_acc[2]);
         chk("result_3", result_3, m_acc[3]);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_run(input int n);
      i_num_cnt = 31'(n);
      i_run     = 1'b1;
      tick();
      i_run     = 1'b0;
   endtask

   // lat counts rising edges since the run sample; cycle 0 is lat 1
   task automatic wait_done(input int lat0, input int limit, output int lat, output int rd,
                            output int wr, output int frd, output int fwr);
      lat = lat0; rd = 0; wr = 0; frd = -1; fwr = -1;
      while (!o_done && lat < limit) begin
         if (o_read)  begin rd++; if (frd < 0) frd = lat; end
         if (o_write) begin wr++; if (fwr < 0) fwr = lat; end
         tick();
         lat++;
      end
      if (!o_done) begin
         n_cmp++;
         n_err++;
         $display("FAIL done_timeout: no o_done within %0d cycles", limit);
      end
   endtask

   task automatic chk_results(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
      chk({tag, "_r0"}, result_0, e0);
      chk({tag, "_r1"}, result_1, e1);
      chk({tag, "_r2"}, result_2, e2);
      chk({tag, "_r3"}, result_3, e3);
   endtask

   initial begin
      int lat, rd, wr, frd, fwr;
      for (int i = 0; i < 4096; i++) begin mem0[i] = 0; mem1[i] = 0; mem2[i] = 0; end
      reset_n = 1'b0; i_run = 1'b0; i_num_cnt = '0;
      tick();
      reset_n = 1'b1;
      chk("rst_idle", o_idle, 1);
      chk("rst_done", o_done, 0);
      chk("rst_ce",   {ce_b0, ce_b1, ce_b2}, 0);
      chk("rst_addr", addr_b0, 0);
      chk_results("rst", 0, 0, 0, 0);
      tick();

      // N=1
      mem0[0] = 32'h01020304; mem1[0] = 32'h05060708; mem2[0] = 32'h0A0B0C0D;
      pulse_run(1);
      wait_done(1, 20, lat, rd, wr, frd, fwr);
      chk("n1_latency", lat, 3);
      chk_results("n1", 15, 23, 33, 45);
      tick();

      // N=4, all ones
      for (int i = 0; i < 4; i++) begin mem0[i] = '1; mem1[i] = '1; mem2[i] = '1; end
      pulse_run(4);
      wait_done(1, 20, lat, rd, wr, frd, fwr);
      chk("n4_latency", lat, 6);
      chk("n4_reads", rd, 4);
      chk("n4_writes", wr, 4);
      chk("n4_first_read", frd, 1);
      chk("n4_first_write", fwr, 2);
      chk_results("n4", 261120, 261120, 261120, 261120);
      tick();

      // N=4096, random bytes
      for (int i = 0; i < 4096; i++) begin
         mem0[i] = $urandom; mem1[i] = $urandom; mem2[i] = $urandom;
      end
      pulse_run(4096);
      wait_done(1, 5000, lat, rd, wr, frd, fwr);
      chk("n4096_latency", lat, 4098);
      chk("n4096_reads", rd, 4096);
      chk_results("n4096", golden(0, 4096), golden(1, 4096), golden(2, 4096), golden(3, 4096));
      tick();

      // N=0
      pulse_run(0);
      wait_done(1, 20, lat, rd, wr, frd, fwr);
      chk("n0_latency", lat, 1);
      chk("n0_reads", rd, 0);
      chk_results("n0", 0, 0, 0, 0);
      tick();

      // run during RUN is ignored
      pulse_run(8);
      tick(); tick();
      i_num_cnt = 31'd3; i_run = 1'b1;
      tick();
      i_run = 1'b0;
      wait_done(4, 40, lat, rd, wr, frd, fwr);
      chk("b2b_latency", lat, 10);
      chk_results("b2b", golden(0, 8), golden(1, 8), golden(2, 8), golden(3, 8));
      tick();

      // fresh run clears before accumulating
      pulse_run(2);
      chk("clr_r0_cycle0", result_0, 0);
      chk("clr_r3_cycle0", result_3, 0);
      wait_done(1, 20, lat, rd, wr, frd, fwr);
      chk("n2_latency", lat, 4);
      chk_results("n2", golden(0, 2), golden(1, 2), golden(2, 2), golden(3, 2));
      tick();

      // reset mid-run
      pulse_run(100);
      repeat (5) tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("mid_rst_idle", o_idle, 1);
      chk("mid_rst_ce", {ce_b0, ce_b1, ce_b2}, 0);
      chk("mid_rst_read", o_read, 0);
      chk_results("mid_rst", 0, 0, 0, 0);
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
